// File: rtl/trng_ctrl.sv
// Ring-oscillator sample sequencer: synchronise, rate-divide, health-test, debias
// and pack raw bits into words handed out over valid/ready.
`timescale 1ns/1ps
module trng_ctrl #(
    parameter int WORD_W    = 32,
    parameter int DIV_W     = 8,
    parameter int REP_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DIV_W-1:0]  div,
    input  logic              raw_bit,
    output logic [WORD_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              health_fail,
    output logic              busy
);
    localparam int BIT_W = $clog2(WORD_W);

    typedef enum logic [1:0] {IDLE, FILL, HOLD, FAIL} state_t;

    state_t            r_state, w_state_next;
    logic              r_sync1, r_sync2;
    logic [DIV_W-1:0]  r_div_cnt, w_div_cnt_next;
    logic              r_pair, w_pair_next;
    logic              r_first, w_first_next;
    logic [BIT_W-1:0]  r_bit_cnt, w_bit_cnt_next;
    logic [7:0]        r_rep_cnt, w_rep_cnt_next;
    logic              r_prev, w_prev_next;
    logic              r_have_prev, w_have_prev_next;
    logic [WORD_W-1:0] r_shift, w_shift_next;
    logic [WORD_W-1:0] r_data, w_data_next;
    logic              r_valid, w_valid_next;
    logic              r_hfail, w_hfail_next;

    logic              w_tick;
    logic [7:0]        w_rep_inc;
    logic [7:0]        w_rep_sample;
    logic              w_trip;
    logic [WORD_W-1:0] w_shift_ins;

    // >= rather than == so a live shrink of div cannot strand the counter above it
    assign w_tick       = (r_state == FILL) && (r_div_cnt >= div);
    assign w_rep_inc    = (r_rep_cnt == 8'hFF) ? r_rep_cnt : r_rep_cnt + 8'd1;
    assign w_rep_sample = (!r_have_prev || (r_sync2 != r_prev)) ? 8'd1 : w_rep_inc;
    assign w_trip       = (w_rep_sample == 8'(REP_LIMIT));

    // Kept debiased bit (first half of the pair) lands at position bit_cnt.
    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_ins
        assign w_shift_ins[gi] = (r_bit_cnt == BIT_W'(gi)) ? r_first : r_shift[gi];
    end

    always_comb begin
        w_state_next     = r_state;
        w_div_cnt_next   = r_div_cnt;
        w_pair_next      = r_pair;
        w_first_next     = r_first;
        w_bit_cnt_next   = r_bit_cnt;
        w_rep_cnt_next   = r_rep_cnt;
        w_prev_next      = r_prev;
        w_have_prev_next = r_have_prev;
        w_shift_next     = r_shift;
        w_data_next      = r_data;
        w_valid_next     = r_valid;
        w_hfail_next     = r_hfail;

        if (!en) begin
            w_state_next = IDLE;
            w_valid_next = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_next     = FILL;
                    w_div_cnt_next   = '0;
                    w_pair_next      = 1'b0;
                    w_bit_cnt_next   = '0;
                    w_rep_cnt_next   = '0;
                    w_have_prev_next = 1'b0;
                    w_shift_next     = '0;
                    w_hfail_next     = 1'b0;
                end
                FILL: begin
                    w_div_cnt_next = w_tick ? '0 : r_div_cnt + DIV_W'(1);
                    if (w_tick) begin
                        w_rep_cnt_next   = w_rep_sample;
                        w_prev_next      = r_sync2;
                        w_have_prev_next = 1'b1;
                        if (w_trip) begin
                            w_hfail_next = 1'b1;
                            w_pair_next  = 1'b0;
                            w_state_next = FAIL;
                        end else if (!r_pair) begin
                            w_pair_next  = 1'b1;
                            w_first_next = r_sync2;
                        end else begin
                            w_pair_next = 1'b0;
                            if (r_first != r_sync2) begin
                                w_shift_next   = w_shift_ins;
                                w_bit_cnt_next = r_bit_cnt + BIT_W'(1);
                                if (r_bit_cnt == BIT_W'(WORD_W - 1)) begin
                                    w_data_next    = w_shift_ins;
                                    w_valid_next   = 1'b1;
                                    w_bit_cnt_next = '0;
                                    w_state_next   = HOLD;
                                end
                            end
                        end
                    end
                end
                HOLD: begin
                    if (r_valid && ready) begin
                        w_valid_next   = 1'b0;
                        w_bit_cnt_next = '0;
                        w_pair_next    = 1'b0;
                        w_shift_next   = '0;
                        w_state_next   = FILL;
                    end
                end
                default: begin
                    w_valid_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_div_cnt   <= '0;
            r_pair      <= 1'b0;
            r_first     <= 1'b0;
            r_bit_cnt   <= '0;
            r_rep_cnt   <= '0;
            r_prev      <= 1'b0;
            r_have_prev <= 1'b0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_hfail     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sync1     <= raw_bit;
            r_sync2     <= r_sync1;
            r_div_cnt   <= w_div_cnt_next;
            r_pair      <= w_pair_next;
            r_first     <= w_first_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_rep_cnt   <= w_rep_cnt_next;
            r_prev      <= w_prev_next;
            r_have_prev <= w_have_prev_next;
            r_shift     <= w_shift_next;
            r_data      <= w_data_next;
            r_valid     <= w_valid_next;
            r_hfail     <= w_hfail_next;
        end
    end

    assign data        = r_data;
    assign valid       = r_valid;
    assign health_fail = r_hfail;
    assign busy        = (r_state == FILL);
endmodule

// File: tb/tb_trng_ctrl.sv
// Bench for trng_ctrl: table of raw-sample streams with expected words, scoreboarded
// on the valid/ready handshake, plus hand sequences for hold, abort, health and reset.
`timescale 1ns/1ps
module tb_trng_ctrl;
    localparam int WORD_W = 8, DIV_W = 8, REP_LIMIT = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              en = 1'b0;
    logic              raw_bit = 1'b0;
    logic              ready = 1'b0;
    logic [DIV_W-1:0]  div = '0;
    logic [WORD_W-1:0] data;
    logic              valid, health_fail, busy;

    int checks = 0;
    int errors = 0;
    logic [WORD_W-1:0] exp_q[$];

    typedef struct {
        logic [31:0] stream;    // raw samples, sample 0 in bit 0
        logic [7:0]  dv;
        logic [7:0]  exp_data;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    trng_ctrl #(.WORD_W(WORD_W), .DIV_W(DIV_W), .REP_LIMIT(REP_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .div(div), .raw_bit(raw_bit),
        .data(data), .valid(valid), .ready(ready),
        .health_fail(health_fail), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Scoreboard: one word retired per accepted handshake.
    always @(negedge clk) begin : sb_mon
        logic [WORD_W-1:0] e;
        if (rst_n && valid && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got word %02h, expected none", data);
            end else begin
                e = exp_q.pop_front();
                $display("txn: data=%02h expected=%02h", data, e);
                chk("sb_data", data, e);
            end
        end
    end

    // Sample j is held for div+1 cycles so the synchronised copy is present on tick j.
    task automatic run_word(input vec_t v, input int abort_at);
        int per;
        per = int'(v.dv) + 1;
        div = v.dv;
        @(posedge clk); #1;
        raw_bit = v.stream[0];
        if (abort_at == 0) exp_q.push_back(v.exp_data);
        for (int i = 1; i < 32 * per + 4; i++) begin
            @(posedge clk); #1;
            if (i == 1) en = 1'b1;
            if (i == abort_at) begin
                en = 1'b0;
                return;
            end
            if ((i % per == 0) && (i / per < 32)) raw_bit = v.stream[i / per];
            if (i == 3) chk("fill_busy", busy, 1);
            if (valid) break;
        end
        chk("valid_rise", valid, 1);
        chk("no_health_fail", health_fail, 0);
        chk("hold_not_busy", busy, 0);
    endtask

    task automatic accept();
        @(posedge clk); #1 ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        chk("valid_drop", valid, 0);
        chk("refill_busy", busy, 1);
        en = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        vecs[0] = '{32'h9999_9999, 8'd0, 8'h55};   // pairs 10,01 alternating
        vecs[1] = '{32'h5555_5555, 8'd3, 8'hFF};   // toggling raw, slow tick
        vecs[2] = '{32'hAA49_7687, 8'd1, 8'hB9};   // 00/11 pairs interleaved
        vecs[3] = '{32'hAAAA_AAAA, 8'd2, 8'h00};
        vecs[4] = '{32'h0000_AA55, 8'd0, 8'h0F};

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_hfail", health_fail, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_rst", busy, 0);

        for (int v = 0; v < 5; v++) begin
            run_word(vecs[v], 0);
            if (v == 0) begin
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    chk("hold_data", data, vecs[0].exp_data);
                    chk("hold_valid", valid, 1);
                    chk("hold_frozen", busy, 0);
                end
            end
            accept();
        end

        // Abort with five bits packed; data keeps the last word.
        run_word(vecs[0], 12);
        @(posedge clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", valid, 0);
        chk("abort_data_kept", data, vecs[4].exp_data);
        run_word(vecs[2], 0);
        accept();

        // Stuck-at-1 raw bit trips the repetition test on the 16th tick.
        div = '0;
        raw_bit = 1'b1;
        repeat (3) @(posedge clk);
        #1 en = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            if (k == 16) begin
                chk("rep_pre_hfail", health_fail, 0);
                chk("rep_pre_busy", busy, 1);
            end
            if (k == 17) begin
                chk("rep_hfail", health_fail, 1);
                chk("rep_fail_busy", busy, 0);
                chk("rep_valid", valid, 0);
            end
        end
        repeat (4) @(posedge clk);
        #1;
        chk("fail_sticky", health_fail, 1);
        chk("fail_no_busy", busy, 0);
        en = 1'b0;
        @(posedge clk); #1;
        chk("idle_hfail_kept", health_fail, 1);
        en = 1'b1;
        @(posedge clk); #1;
        chk("reentry_hfail_clr", health_fail, 0);
        chk("reentry_busy", busy, 1);
        en = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset while holding a word.
        run_word(vecs[0], 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_data", data, 0);
        chk("arst_hfail", health_fail, 0);
        chk("arst_busy", busy, 0);
        exp_q.delete();
        en = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        run_word(vecs[4], 0);
        accept();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending words, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, expected finish before 300us");
        $fatal(1, "watchdog");
    end
endmodule
